// File: rtl/conv_operand_feeder.sv
// conv_operand_feeder: sequences one convolution window into a PE chain.
// Holds an N-entry weight file, issues one tap (x, w, initial psum) per
// accepted activation, then waits D cycles for the chain to drain and pulses
// o_done.
module conv_operand_feeder #(
  parameter int XW  = 8,
  parameter int WW  = 8,
  parameter int BW1 = 16,
  parameter int N   = 9,
  parameter int D   = 4,
  parameter int AW  = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_w_we,
  input  logic [AW-1:0]  i_w_addr,
  input  logic [WW-1:0]  i_w_data,
  input  logic [BW1-1:0] i_bias,
  input  logic           i_start,
  output logic           o_busy,
  input  logic           i_x_valid,
  input  logic [XW-1:0]  i_x,
  output logic           o_x_ready,
  output logic [XW-1:0]  o_x,
  output logic [WW-1:0]  o_w,
  output logic [BW1-1:0] o_psum,
  output logic           o_valid,
  output logic           o_first,
  output logic           o_last,
  output logic           o_done
);

  localparam int TCW = $clog2(N + 1);
  localparam int DCW = $clog2(D + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [TCW-1:0]        r_tap_cnt;
  logic [DCW-1:0]        r_drain_cnt;
  logic signed [BW1-1:0] r_bias;
  logic signed [WW-1:0]  r_wmem [2**AW];

  logic signed [XW-1:0]  r_x_p1;
  logic signed [WW-1:0]  r_w_p1;
  logic signed [BW1-1:0] r_psum_p1;
  logic                  r_vld_p1;
  logic                  r_first_p1;
  logic                  r_last_p1;

  logic                  w_xfer;
  logic                  w_tap_first;
  logic                  w_tap_last;
  logic                  w_drain_end;
  logic                  w_w_addr_ok;

  // The feeder is only ready in FEED, so the handshake reduces to valid in FEED.
  assign w_xfer      = (r_state == S_FEED) && i_x_valid;
  assign w_tap_first = (r_tap_cnt == '0);
  assign w_tap_last  = (r_tap_cnt == TCW'(N - 1));
  assign w_drain_end = (r_drain_cnt == DCW'(D));
  assign w_w_addr_ok = ({{(32-AW){1'b0}}, i_w_addr} < 32'(N));

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_x_ready   = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_FEED;
      end
      S_FEED: begin
        o_x_ready = 1'b1;
        o_busy    = 1'b1;
        if (w_xfer && w_tap_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (w_drain_end) begin
          o_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tap and drain counters plus the bias latched at window start.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tap_cnt   <= '0;
      r_drain_cnt <= '0;
      r_bias      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_bias    <= $signed(i_bias);
            r_tap_cnt <= '0;
          end
        end
        S_FEED: begin
          if (w_xfer) begin
            if (w_tap_last) r_drain_cnt <= '0;
            else            r_tap_cnt   <= r_tap_cnt + TCW'(1);
          end
        end
        S_DRAIN: begin
          // The o_last cycle is drain count 0; o_done fires at count D.
          if (!w_drain_end) r_drain_cnt <= r_drain_cnt + DCW'(1);
        end
        default: ;
      endcase
    end
  end

  // Weight file: written only while idle and only for addresses below N.
  always_ff @(posedge i_clk) begin
    if (i_w_we && (r_state == S_IDLE) && w_w_addr_ok)
      r_wmem[i_w_addr] <= $signed(i_w_data);
  end

  // Stage p0 -> p1: register the tap one cycle after its handshake; data holds when idle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_x_p1     <= '0;
      r_w_p1     <= '0;
      r_psum_p1  <= '0;
      r_vld_p1   <= 1'b0;
      r_first_p1 <= 1'b0;
      r_last_p1  <= 1'b0;
    end else begin
      r_vld_p1   <= w_xfer;
      r_first_p1 <= w_xfer && w_tap_first;
      r_last_p1  <= w_xfer && w_tap_last;
      if (w_xfer) begin
        r_x_p1    <= $signed(i_x);
        r_w_p1    <= r_wmem[AW'(r_tap_cnt)];
        r_psum_p1 <= w_tap_first ? r_bias : '0;
      end
    end
  end

  assign o_x     = r_x_p1;
  assign o_w     = r_w_p1;
  assign o_psum  = r_psum_p1;
  assign o_valid = r_vld_p1;
  assign o_first = r_first_p1;
  assign o_last  = r_last_p1;

endmodule

// File: tb/tb_conv_operand_feeder.sv
// Directed bench for conv_operand_feeder: a 3-tap/4-cycle-drain instance and
// a 1-tap/1-cycle-drain instance driven from one linear stimulus sequence.
module tb_conv_operand_feeder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: N=3, D=4
  logic        rst_n, w_we, start, x_valid;
  logic [3:0]  w_addr;
  logic [7:0]  w_data, x;
  logic [15:0] bias;
  logic        busy, x_ready, vld, first, last, done;
  logic [7:0]  ox, ow;
  logic [15:0] opsum;

  conv_operand_feeder #(.XW(8), .WW(8), .BW1(16), .N(3), .D(4), .AW(4)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_w_we(w_we), .i_w_addr(w_addr),
    .i_w_data(w_data), .i_bias(bias), .i_start(start), .o_busy(busy),
    .i_x_valid(x_valid), .i_x(x), .o_x_ready(x_ready), .o_x(ox), .o_w(ow),
    .o_psum(opsum), .o_valid(vld), .o_first(first), .o_last(last), .o_done(done)
  );

  // Instance B: N=1, D=1
  logic        b_rst_n, b_w_we, b_start, b_x_valid;
  logic [0:0]  b_w_addr;
  logic [7:0]  b_w_data, b_x;
  logic [15:0] b_bias;
  logic        b_busy, b_x_ready, b_vld, b_first, b_last, b_done;
  logic [7:0]  b_ox, b_ow;
  logic [15:0] b_opsum;

  conv_operand_feeder #(.XW(8), .WW(8), .BW1(16), .N(1), .D(1), .AW(1)) u_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_w_we(b_w_we), .i_w_addr(b_w_addr),
    .i_w_data(b_w_data), .i_bias(b_bias), .i_start(b_start), .o_busy(b_busy),
    .i_x_valid(b_x_valid), .i_x(b_x), .o_x_ready(b_x_ready), .o_x(b_ox), .o_w(b_ow),
    .o_psum(b_opsum), .o_valid(b_vld), .o_first(b_first), .o_last(b_last), .o_done(b_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tap(input string tag, input int ev, input int ex, input int ew,
                         input int ep, input int ef, input int el);
    chk({tag, "_vld"},   int'(vld), ev);
    chk({tag, "_x"},     int'($signed(ox)), ex);
    chk({tag, "_w"},     int'($signed(ow)), ew);
    chk({tag, "_psum"},  int'($signed(opsum)), ep);
    chk({tag, "_first"}, int'(first), ef);
    chk({tag, "_last"},  int'(last), el);
  endtask

  task automatic wr(input int a, input int d);
    w_we = 1'b1; w_addr = 4'(a); w_data = 8'(d);
    tick();
    w_we = 1'b0;
  endtask

  task automatic start_win(input int b);
    start = 1'b1; bias = 16'(b);
    tick();
    start = 1'b0;
  endtask

  // Feed one tap back-to-back and check it on the following cycle.
  task automatic feed(input string tag, input int xv, input int ew, input int ep,
                      input int ef, input int el);
    x_valid = 1'b1; x = 8'(xv);
    tick();
    x_valid = 1'b0;
    chk_tap(tag, 1, xv, ew, ep, ef, el);
  endtask

  // After the o_last cycle: D-1 quiet cycles, then one o_done cycle.
  task automatic drain(input string tag);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk({tag, "_nodone"}, int'(done), 0);
    end
    tick();
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_busy_done"}, int'(busy), 1);
  endtask

  initial begin
    int nd;
    rst_n = 1'b0; w_we = 1'b0; w_addr = '0; w_data = '0; bias = '0;
    start = 1'b0; x_valid = 1'b0; x = '0;
    b_rst_n = 1'b0; b_w_we = 1'b0; b_w_addr = '0; b_w_data = '0; b_bias = '0;
    b_start = 1'b0; b_x_valid = 1'b0; b_x = '0;
    tick(); tick();

    // Reset state
    chk_tap("rst", 0, 0, 0, 0, 0, 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(x_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rstb_busy", int'(b_busy), 0);
    rst_n = 1'b1; b_rst_n = 1'b1;
    tick();

    // 1: basic window
    wr(0, 2); wr(1, -1); wr(2, 3);
    wr(3, 55);  // out of range, ignored
    chk("t1_idle_ready", int'(x_ready), 0);
    start_win(10);
    chk("t1_ready", int'(x_ready), 1);
    chk("t1_busy", int'(busy), 1);
    feed("t1_tap0", 5, 2, 10, 1, 0);
    feed("t1_tap1", 6, -1, 0, 0, 0);
    feed("t1_tap2", 7, 3, 0, 0, 1);
    chk("t1_ready_drain", int'(x_ready), 0);
    chk("t1_done_last", int'(done), 0);
    drain("t1");
    tick();
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_done_after", int'(done), 0);

    // 2: gapped valid 1,0,0,1,0,1
    start_win(10);
    feed("t2_tap0", 5, 2, 10, 1, 0);
    tick();
    chk_tap("t2_gap0", 0, 5, 2, 10, 0, 0);
    tick();
    chk_tap("t2_gap1", 0, 5, 2, 10, 0, 0);
    feed("t2_tap1", 6, -1, 0, 0, 0);
    tick();
    chk_tap("t2_gap2", 0, 6, -1, 0, 0, 0);
    feed("t2_tap2", 7, 3, 0, 0, 1);
    drain("t2");
    tick();

    // 3: weight write and start during FEED are ignored
    start_win(10);
    feed("t3_tap0", 5, 2, 10, 1, 0);
    w_we = 1'b1; w_addr = 4'd0; w_data = 8'd99; start = 1'b1;
    tick();
    w_we = 1'b0; start = 1'b0;
    chk("t3_gap_vld", int'(vld), 0);
    feed("t3_tap1", 6, -1, 0, 0, 0);
    feed("t3_tap2", 7, 3, 0, 0, 1);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) nd++;
    end
    chk("t3_done_count", nd, 1);
    chk("t3_idle_busy", int'(busy), 0);

    // 4: next window keeps weight 2; reset after the 2nd tap handshake
    start_win(10);
    feed("t4_tap0", 5, 2, 10, 1, 0);
    feed("t4_tap1", 6, -1, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_tap("t4_rst", 0, 0, 0, 0, 0, 0);
    chk("t4_rst_busy", int'(busy), 0);
    chk("t4_rst_ready", int'(x_ready), 0);
    chk("t4_rst_done", int'(done), 0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) nd++;
    end
    chk("t4_no_done", nd, 0);
    chk("t4_idle_busy", int'(busy), 0);
    start_win(-3);
    feed("t4b_tap0", 5, 2, -3, 1, 0);
    feed("t4b_tap1", 6, -1, 0, 0, 0);
    feed("t4b_tap2", 7, 3, 0, 0, 1);
    drain("t4b");

    // 6: start held across o_done
    tick();
    start_win(10);
    feed("t6_tap0", 1, 2, 10, 1, 0);
    feed("t6_tap1", 2, -1, 0, 0, 0);
    feed("t6_tap2", 3, 3, 0, 0, 1);
    start = 1'b1;
    drain("t6");
    chk("t6_ready_done", int'(x_ready), 0);
    tick();
    chk("t6_ready_idle", int'(x_ready), 0);
    chk("t6_busy_idle", int'(busy), 0);
    tick();
    chk("t6_ready_feed", int'(x_ready), 1);
    start = 1'b0;

    // 5: N=1, D=1 instance
    b_w_we = 1'b1; b_w_addr = 1'b0; b_w_data = 8'(-4);
    tick();
    b_w_addr = 1'b1; b_w_data = 8'd77;  // out of range, ignored
    tick();
    b_w_we = 1'b0;
    b_start = 1'b1; b_bias = 16'(-7);
    tick();
    b_start = 1'b0;
    chk("t5_ready", int'(b_x_ready), 1);
    b_x_valid = 1'b1; b_x = 8'd3;
    tick();
    b_x_valid = 1'b0;
    chk("t5_vld", int'(b_vld), 1);
    chk("t5_x", int'($signed(b_ox)), 3);
    chk("t5_w", int'($signed(b_ow)), -4);
    chk("t5_psum", int'($signed(b_opsum)), -7);
    chk("t5_first", int'(b_first), 1);
    chk("t5_last", int'(b_last), 1);
    chk("t5_nodone", int'(b_done), 0);
    chk("t5_ready_drain", int'(b_x_ready), 0);
    tick();
    chk("t5_done", int'(b_done), 1);
    chk("t5_busy_done", int'(b_busy), 1);
    chk("t5_vld_off", int'(b_vld), 0);
    tick();
    chk("t5_done_off", int'(b_done), 0);
    chk("t5_busy_off", int'(b_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_operand_feeder.md
Name: conv_operand_feeder

Overview:
Transmit-side sequencer that drives a processing-element chain's x, w and initial psum inputs for one convolution window.
- Holds an N-entry weight register file loaded through a write port.
- Accepts an activation stream over valid/ready.
- Issues N taps (one tap per accepted x), then waits D cycles for the chain to drain and pulses done.
- Sits between the activation buffer and the PE chain input.

Parameters:
XW, 8, activation width (signed)
WW, 8, weight width (signed)
BW1, 16, initial psum / bias width (signed)
N, 9, taps per window (N >= 1)
D, 4, PE chain latency in cycles (D >= 1)
AW, 4, weight address width (2^AW >= N)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  synchronous active-low reset
i_w_we  in  1  weight write enable
i_w_addr  in  AW  weight write address
i_w_data  in  WW  weight write data (signed)
i_bias  in  BW1  bias, sampled on accepted start
i_start  in  1  start-window request
o_busy  out  1  high in FEED and DRAIN
i_x_valid  in  1  activation valid
i_x  in  XW  activation data (signed)
o_x_ready  out  1  feeder can accept activation
o_x  out  XW  activation to PE chain
o_w  out  WW  weight to PE chain
o_psum  out  BW1  initial psum to PE chain
o_valid  out  1  o_x/o_w/o_psum carry a tap this cycle
o_first  out  1  tap index 0 (qualified by o_valid)
o_last  out  1  tap index N-1 (qualified by o_valid)
o_done  out  1  one-cycle pulse at end of window

Behaviour:
- Clock and reset: single clock i_clk. i_rst_n is sampled on the rising edge only.
- Reset: state <= IDLE; tap and drain counters <= 0; bias register <= 0.
  - All outputs <= 0: o_x, o_w, o_psum, o_valid, o_first, o_last, o_done, o_busy, o_x_ready.
  - Weight file is not reset.
  - Reset mid-window aborts immediately. No o_done is produced for the aborted window.
- Weight writes: accepted only when o_busy=0, writing wmem[i_w_addr] <= i_w_data. Writes while busy are ignored. Writes with i_w_addr >= N are ignored.
- IDLE:
  - o_x_ready=0.
  - On i_start=1: latch i_bias, tap_cnt <= 0, go to FEED.
- FEED:
  - o_x_ready=1 (combinational from state).
  - Transfer = i_x_valid & o_x_ready. On a transfer, the next cycle registers:
    - o_x <= i_x
    - o_w <= wmem[tap_cnt]
    - o_psum <= bias if tap_cnt==0, else 0
    - o_valid <= 1
    - o_first <= (tap_cnt==0)
    - o_last <= (tap_cnt==N-1)
  - Latency is 1 cycle from the handshake to o_valid.
  - With no transfer: o_valid, o_first and o_last are 0; o_x, o_w and o_psum hold their previous values.
  - On a transfer with tap_cnt==N-1: go to DRAIN with drain_cnt <= 0; o_x_ready drops the following cycle. Otherwise tap_cnt increments.
  - N=1: o_first and o_last are high in the same cycle.
- DRAIN:
  - o_x_ready=0. drain_cnt counts cycles, starting with the o_last cycle as count 0.
  - o_done=1 exactly D cycles after the cycle in which o_last=1, then IDLE next cycle.
  - o_busy remains 1 during the o_done cycle.
- Start while busy: i_start is ignored in FEED and DRAIN, including the o_done cycle. A start in the first IDLE cycle after o_done is accepted.
- Arithmetic: no arithmetic beyond counters. Signed values pass through unmodified. Counter widths are $clog2(N+1) and $clog2(D+1).

Test Plan:
1. Reset, N=3, D=4, weights {2,-1,3}, bias=10, then start; stream x=5,6,7 back-to-back.
   - Expect (o_x,o_w,o_psum) = (5,2,10), (6,-1,0), (7,3,0) on consecutive cycles, each 1 cycle after its handshake.
   - o_first on the 1st tap, o_last on the 3rd; o_done exactly 4 cycles after o_last; o_busy low the cycle after o_done.
2. Same setup, i_x_valid toggling 1,0,0,1,0,1.
   - Expect o_valid only in the 3 cycles after the handshakes; o_x/o_w hold during gaps; tap order unchanged.
3. During FEED: write wmem[0]=99 and pulse i_start.
   - Expect both ignored; the next window still uses weight 2; only one o_done for the window.
4. Reset asserted for 1 cycle after the 2nd tap is accepted.
   - Expect every output 0 the next cycle and state IDLE; no o_done; the next start runs a full 3-tap window with the retained weights.
5. N=1, D=1, weight -4, bias -7, x=3.
   - Expect a single tap (3,-4,-7) with o_first=o_last=1, and o_done the following cycle.
6. i_start held continuously across o_done.
   - Expect start ignored in the o_done cycle and accepted in the next IDLE cycle: o_x_ready rises 2 cycles after o_done.
